// File: rtl/tbl_seed_pipe.sv
// Two-stage seed-table unit: exponent/mantissa -> per-bank table index -> entry RAM,
// with a mantissa-truncate mode. The entry RAM is swept to zero after every reset.
module tbl_seed_pipe #(
  parameter int                  ENTRY_W  = 68,
  parameter int                  IDX_BITS = 6,
  parameter int                  NFUNC    = 4,
  parameter logic [12*NFUNC-1:0] EXP_BASE = {12'd2045, 12'd2045, 12'd2041, 12'd2040},
  parameter logic [NFUNC-1:0]    SIGN_FIX = 4'b0101
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rd_vld,
  output logic                                rd_rdy,
  input  logic [$clog2(NFUNC)-1:0]            rd_func,
  input  logic                                rd_mode,
  input  logic [67:0]                         rd_A,
  input  logic                                wr_vld,
  output logic                                wr_rdy,
  input  logic [$clog2(NFUNC<<IDX_BITS)-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0]                  wr_data,
  output logic                                res_vld,
  input  logic                                res_rdy,
  output logic [ENTRY_W-1:0]                  res,
  output logic                                res_oor,
  output logic                                init_done
);

  localparam int         FUNC_W  = $clog2(NFUNC);
  localparam int         DEPTH   = NFUNC << IDX_BITS;
  localparam int         ADDR_W  = $clog2(DEPTH);
  localparam logic [11:0] IDX_MAX = 12'(IDX_BITS);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                clr_we;

  logic [ENTRY_W-1:0]  ram [DEPTH];
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_wa;
  logic [ENTRY_W-1:0]  ram_wd;

  logic                advance, rd_fire, wr_fire;

  logic [11:0]         base, e;
  logic                oor_c;
  logic [IDX_BITS-2:0] mant_hi;
  logic [IDX_BITS-1:0] idx_c, tmask;
  logic [67:0]         keep, trunc_c;

  logic                s1_vld, s1_mode, s1_oor, s1_sign;
  logic [ADDR_W-1:0]   s1_addr;
  logic [ENTRY_W-1:0]  s1_trunc;

  logic [ENTRY_W-1:0]  ram_q, lookup, res_nxt;
  logic                s2_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
  end

  always_comb begin
    clr_we    = 1'b0;
    wr_rdy    = 1'b0;
    init_done = 1'b0;
    case (state)
      INIT:    clr_we = 1'b1;
      RUN: begin
        wr_rdy    = 1'b1;
        init_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign advance = !s2_vld || res_rdy;
  assign rd_rdy  = init_done && advance;
  assign rd_fire = rd_vld && rd_rdy;
  assign wr_fire = wr_vld && wr_rdy;
  assign res_vld = s2_vld;

  // The clear sweep owns the write port until the FSM reaches RUN.
  assign ram_we = !rst && (clr_we || wr_fire);
  assign ram_wa = clr_we ? clr_cnt : wr_addr;
  assign ram_wd = clr_we ? '0 : wr_data;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

  always_comb begin
    base = EXP_BASE[11:0];
    for (int f = 0; f < NFUNC; f++)
      if (rd_func == FUNC_W'(f)) base = EXP_BASE[12*f +: 12];
    e       = rd_A[65:54] - base;
    oor_c   = e > IDX_MAX;
    mant_hi = rd_A[53 -: IDX_BITS-1];
    idx_c   = '0;
    tmask   = '0;
    if (!oor_c && e != 12'd0) idx_c = {1'b1, mant_hi >> (IDX_MAX - e)};
    // Truncation keeps the leading e mantissa bits of the index field.
    if (!oor_c) tmask = ~({IDX_BITS{1'b1}} >> e);
    keep                 = '0;
    keep[67:54]          = '1;
    keep[53 -: IDX_BITS] = tmask;
    trunc_c              = rd_A & keep;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_mode  <= 1'b0;
      s1_oor   <= 1'b0;
      s1_sign  <= 1'b0;
      s1_addr  <= '0;
      s1_trunc <= '0;
    end else if (advance) begin
      s1_vld <= rd_fire;
      if (rd_fire) begin
        s1_mode  <= rd_mode;
        s1_oor   <= oor_c;
        s1_sign  <= SIGN_FIX[rd_func] & rd_A[64];
        s1_addr  <= {rd_func, idx_c};
        s1_trunc <= ENTRY_W'(trunc_c);
      end
    end
  end

  // Write-first: a write landing on the address being read this cycle wins.
  always_comb begin
    ram_q  = (wr_fire && wr_addr == s1_addr) ? wr_data : ram[s1_addr];
    lookup = ram_q ^ (ENTRY_W'(s1_sign) << 64);
    if (s1_oor) lookup = '0;
    res_nxt = s1_mode ? s1_trunc : lookup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      res     <= '0;
      res_oor <= 1'b0;
    end else if (advance) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        res     <= res_nxt;
        res_oor <= s1_oor;
      end
    end
  end

endmodule

// File: tb/tb_tbl_seed_pipe.sv
// Scoreboard bench for tbl_seed_pipe: directed lookups/truncations push expected
// results; a negedge monitor pops and compares every accepted output.
module tb_tbl_seed_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_vld, rd_rdy, rd_mode;
  logic [1:0]  rd_func;
  logic [67:0] rd_A;
  logic        wr_vld, wr_rdy;
  logic [7:0]  wr_addr;
  logic [67:0] wr_data;
  logic        res_vld, res_rdy, res_oor, init_done;
  logic [67:0] res;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [68:0] exp_q [$];
  int          id_q  [$];

  typedef struct packed {
    logic [1:0]  f;
    logic        m;
    logic [67:0] a;
    logic [67:0] er;
    logic        eo;
  } vec_t;

  vec_t vecs [$];

  tbl_seed_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .rd_vld    (rd_vld),
    .rd_rdy    (rd_rdy),
    .rd_func   (rd_func),
    .rd_mode   (rd_mode),
    .rd_A      (rd_A),
    .wr_vld    (wr_vld),
    .wr_rdy    (wr_rdy),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .res       (res),
    .res_oor   (res_oor),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] mkA(input logic [1:0] top, input logic [11:0] ex,
                                      input logic [53:0] mt);
    return {top, ex, mt};
  endfunction

  function automatic vec_t mkV(input logic [1:0] f, input logic m, input logic [67:0] a,
                               input logic [67:0] er, input logic eo);
    vec_t v;
    v.f = f; v.m = m; v.a = a; v.er = er; v.eo = eo;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [68:0] act, input logic [68:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int id, input vec_t v);
    int n = 0;
    rd_vld  = 1'b1;
    rd_func = v.f;
    rd_mode = v.m;
    rd_A    = v.a;
    @(negedge clk);
    while (!rd_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rd_rdy) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL accept_timeout#%0d: rd_rdy stayed 0, expected 1", id);
    end else begin
      exp_q.push_back({v.eo, v.er});
      id_q.push_back(id);
    end
    @(posedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic writeEntry(input logic [7:0] ad, input logic [67:0] d);
    int n = 0;
    wr_vld  = 1'b1;
    wr_addr = ad;
    wr_data = d;
    @(negedge clk);
    while (!wr_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wr_rdy) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL write_timeout: wr_rdy stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    wr_vld = 1'b0;
  endtask

  task automatic waitInit(input string name);
    int cyc = 0;
    while (!rd_rdy && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput(name, cyc, 256);
    checkOutput({name, "_init_done"}, init_done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : monitor
    logic [68:0] ev;
    int          eid;
    forever begin
      @(negedge clk);
      if (!rst && res_vld && res_rdy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("[TB] FAIL unexpected_result: got oor=%b res=%h, expected no output",
                   res_oor, res);
        end else begin
          ev  = exp_q.pop_front();
          eid = id_q.pop_front();
          if ({res_oor, res} !== ev) begin
            n_miss++;
            $display("[TB] FAIL result#%0d: got oor=%b res=%h, expected oor=%b res=%h",
                     eid, res_oor, res, ev[68], ev[67:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rd_vld = 1'b0; rd_func = '0; rd_mode = 1'b0; rd_A = '0;
    wr_vld = 1'b0; wr_addr = '0; wr_data = '0; res_rdy = 1'b1;

    // lookup vectors 0..5, truncate vectors 6..10
    vecs.push_back(mkV(2'd0, 1'b0, mkA(2'b00, 12'd2043, {2'b11, 52'h5_A5A5_A5A5_A5A5}),
                       68'h1_0000_0000_0000_1234, 1'b0));
    vecs.push_back(mkV(2'd1, 1'b0, mkA(2'b00, 12'd2041, 54'h2A_AAAA_AAAA_AAAA),
                       68'hA_BCDE_F012_3456_789A, 1'b0));
    vecs.push_back(mkV(2'd3, 1'b0, mkA(2'b00, 12'd2051, {5'b10101, 49'h0}),
                       68'h5_5AA5_0FF0_1234_CAFE, 1'b0));
    vecs.push_back(mkV(2'd2, 1'b0, mkA(2'b00, 12'd2046, 54'h0),
                       68'h1_0000_0000_0000_0000, 1'b0));
    vecs.push_back(mkV(2'd0, 1'b0, mkA(2'b00, 12'd2047, 54'h3F_FFFF_FFFF_FFFF), 68'h0, 1'b1));
    vecs.push_back(mkV(2'd1, 1'b0, mkA(2'b00, 12'd2000, 54'h1F_0000_0000_0000), 68'h0, 1'b1));
    vecs.push_back(mkV(2'd3, 1'b1, mkA(2'b10, 12'd2048, 54'h3F_FFFF_FFFF_FFFF),
                       mkA(2'b10, 12'd2048, {3'b111, 51'h0}), 1'b0));
    vecs.push_back(mkV(2'd3, 1'b1, mkA(2'b10, 12'd2060, 54'h3F_FFFF_FFFF_FFFF),
                       mkA(2'b10, 12'd2060, 54'h0), 1'b1));
    vecs.push_back(mkV(2'd3, 1'b1, mkA(2'b01, 12'd2045, 54'h3F_FFFF_FFFF_FFFF),
                       mkA(2'b01, 12'd2045, 54'h0), 1'b0));
    vecs.push_back(mkV(2'd1, 1'b1, mkA(2'b11, 12'd2047, 54'h2B_CDEF_0123_4567),
                       mkA(2'b11, 12'd2047, {6'b101011, 48'h0}), 1'b0));
    vecs.push_back(mkV(2'd0, 1'b1, mkA(2'b10, 12'd1000, 54'h3F_FFFF_FFFF_FFFF),
                       mkA(2'b10, 12'd1000, 54'h0), 1'b1));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_res_vld",   res_vld,   0);
    checkOutput("rst_res",       res,       0);
    checkOutput("rst_res_oor",   res_oor,   0);
    checkOutput("rst_rd_rdy",    rd_rdy,    0);
    checkOutput("rst_wr_rdy",    wr_rdy,    0);
    checkOutput("rst_init_done", init_done, 0);

    rst = 1'b0;
    waitInit("init_cycles");

    $display("[TB] first lookup on cleared table");
    applyStimulus(100, mkV(2'd1, 1'b0, mkA(2'b00, 12'd2042, 54'h3F_0000_0000_0000),
                           68'h0, 1'b0));
    checkOutput("latency_t1_vld", res_vld, 0);
    @(posedge clk);
    #1;
    checkOutput("latency_t2_vld", res_vld, 1);
    drain();

    writeEntry(8'h23, 68'h1234);
    writeEntry(8'h40, 68'hA_BCDE_F012_3456_789A);
    writeEntry(8'hF5, 68'h5_5AA5_0FF0_1234_CAFE);

    $display("[TB] back-to-back lookups and truncations");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);
    drain();

    $display("[TB] backpressure burst");
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(20 + i, vecs[i]);
      end
      begin
        res_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("bp_rd_rdy_low", rd_rdy, 0);
        checkOutput("bp_res_vld_held", res_vld, 1);
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
      end
    join
    drain();

    $display("[TB] write/read collisions");
    fork
      applyStimulus(30, mkV(2'd3, 1'b0, vecs[2].a, 68'hE_1111_2222_3333_4444, 1'b0));
      writeEntry(8'hF5, 68'hE_1111_2222_3333_4444);
    join
    drain();
    fork
      applyStimulus(31, mkV(2'd1, 1'b0, vecs[1].a, 68'hD_5555_6666_7777_8888, 1'b0));
      begin
        @(posedge clk);
        #1;
        writeEntry(8'h40, 68'hD_5555_6666_7777_8888);
      end
    join
    drain();

    $display("[TB] reset during burst");
    res_rdy = 1'b0;
    applyStimulus(40, vecs[0]);
    applyStimulus(41, vecs[3]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_res_vld",   res_vld,   0);
    checkOutput("midrst_rd_rdy",    rd_rdy,    0);
    checkOutput("midrst_wr_rdy",    wr_rdy,    0);
    checkOutput("midrst_init_done", init_done, 0);
    exp_q.delete();
    id_q.delete();
    rst     = 1'b0;
    res_rdy = 1'b1;
    waitInit("reinit_cycles");
    applyStimulus(50, mkV(2'd0, 1'b0, vecs[0].a, 68'h1_0000_0000_0000_0000, 1'b0));
    applyStimulus(51, mkV(2'd3, 1'b0, vecs[2].a, 68'h0, 1'b0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
